// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control encodings and default datapath widths.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_NOP = 3'b011,
        ALU_SUB = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SLT = 3'b110
    } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass mux: picks the newest in-flight result for a source register.
// Forwarding is only built when ID_EX_FWD_EN is defined; otherwise the register value passes through.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src_reg,
    input  logic [DATA_W-1:0] reg_value,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_write_reg,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_reg,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] fwd_value
);

`ifdef ID_EX_FWD_EN
    logic src_nonzero;
    logic exm_hit;
    logic wb_hit;

    // Register 0 is hard-wired to zero, so a write to it must never be bypassed.
    assign src_nonzero = |src_reg;
    assign exm_hit     = exm_reg_write && (exm_write_reg == src_reg) && src_nonzero;
    assign wb_hit      = wb_reg_write  && (wb_write_reg  == src_reg) && src_nonzero;

    always_comb begin
        fwd_value = reg_value;
        if (exm_hit) begin
            fwd_value = exm_result;
        end else if (wb_hit) begin
            fwd_value = wb_result;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{src_reg, exm_reg_write, exm_write_reg, exm_result,
                          wb_reg_write, wb_write_reg, wb_result};
    assign fwd_value  = reg_value;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush-to-bubble and operand forwarding into the ALU.
// Forwarding is enabled by defining ID_EX_FWD_EN; the default build passes register-file reads through.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic [DATA_W-1:0] ID_RD1,
    input  logic [DATA_W-1:0] ID_RD2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic [REG_AW-1:0] ID_Rd,
    input  logic              ID_ALU_Src,
    input  logic [2:0]        ID_ALU_Control,
    input  logic              ID_Reg_Write,
    input  logic              ID_Reg_Dst,
    input  logic              EXM_Reg_Write,
    input  logic [REG_AW-1:0] EXM_Write_Reg,
    input  logic [DATA_W-1:0] EXM_Result,
    input  logic              WB_Reg_Write,
    input  logic [REG_AW-1:0] WB_Write_Reg,
    input  logic [DATA_W-1:0] WB_Result,
    output logic [DATA_W-1:0] Src1,
    output logic [DATA_W-1:0] Src2,
    output logic [2:0]        ALU_Control,
    output logic              EX_Valid,
    output logic              EX_Reg_Write,
    output logic [REG_AW-1:0] EX_Write_Reg,
    output logic [DATA_W-1:0] EX_Store_Data
);

    logic              valid_reg;
    logic [DATA_W-1:0] rd1_reg;
    logic [DATA_W-1:0] rd2_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [REG_AW-1:0] rs_reg;
    logic [REG_AW-1:0] rt_reg;
    logic [REG_AW-1:0] rd_reg;
    logic              alu_src_reg;
    logic [2:0]        alu_control_reg;
    logic              reg_write_reg;
    logic              reg_dst_reg;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Flush wins over Stall; a bubble carries the NOP code so the ALU produces 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_reg       <= 1'b0;
            rd1_reg         <= '0;
            rd2_reg         <= '0;
            imm_reg         <= '0;
            rs_reg          <= '0;
            rt_reg          <= '0;
            rd_reg          <= '0;
            alu_src_reg     <= 1'b0;
            alu_control_reg <= ALU_NOP;
            reg_write_reg   <= 1'b0;
            reg_dst_reg     <= 1'b0;
        end else if (Flush) begin
            valid_reg       <= 1'b0;
            rd1_reg         <= '0;
            rd2_reg         <= '0;
            imm_reg         <= '0;
            rs_reg          <= '0;
            rt_reg          <= '0;
            rd_reg          <= '0;
            alu_src_reg     <= 1'b0;
            alu_control_reg <= ALU_NOP;
            reg_write_reg   <= 1'b0;
            reg_dst_reg     <= 1'b0;
        end else if (!Stall) begin
            valid_reg       <= ID_Valid;
            rd1_reg         <= ID_RD1;
            rd2_reg         <= ID_RD2;
            imm_reg         <= ID_Imm;
            rs_reg          <= ID_Rs;
            rt_reg          <= ID_Rt;
            rd_reg          <= ID_Rd;
            alu_src_reg     <= ID_ALU_Src;
            alu_control_reg <= ID_ALU_Control;
            reg_write_reg   <= ID_Reg_Write;
            reg_dst_reg     <= ID_Reg_Dst;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_reg       (rs_reg),
        .reg_value     (rd1_reg),
        .exm_reg_write (EXM_Reg_Write),
        .exm_write_reg (EXM_Write_Reg),
        .exm_result    (EXM_Result),
        .wb_reg_write  (WB_Reg_Write),
        .wb_write_reg  (WB_Write_Reg),
        .wb_result     (WB_Result),
        .fwd_value     (fwd_rs)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_reg       (rt_reg),
        .reg_value     (rd2_reg),
        .exm_reg_write (EXM_Reg_Write),
        .exm_write_reg (EXM_Write_Reg),
        .exm_result    (EXM_Result),
        .wb_reg_write  (WB_Reg_Write),
        .wb_write_reg  (WB_Write_Reg),
        .wb_result     (WB_Result),
        .fwd_value     (fwd_rt)
    );

    // Forwarding stays live while stalled, so held operands follow late results.
    assign Src1          = fwd_rs;
    assign Src2          = alu_src_reg ? imm_reg : fwd_rt;
    assign EX_Store_Data = fwd_rt;
    assign ALU_Control   = alu_control_reg;
    assign EX_Valid      = valid_reg;
    assign EX_Reg_Write  = reg_write_reg & valid_reg;
    assign EX_Write_Reg  = reg_dst_reg ? rd_reg : rt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected EX-side values, a negedge monitor pops and compares.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        ID_Valid = 1'b0;
    logic [31:0] ID_RD1 = '0;
    logic [31:0] ID_RD2 = '0;
    logic [31:0] ID_Imm = '0;
    logic [4:0]  ID_Rs = '0;
    logic [4:0]  ID_Rt = '0;
    logic [4:0]  ID_Rd = '0;
    logic        ID_ALU_Src = 1'b0;
    logic [2:0]  ID_ALU_Control = '0;
    logic        ID_Reg_Write = 1'b0;
    logic        ID_Reg_Dst = 1'b0;
    logic        EXM_Reg_Write = 1'b0;
    logic [4:0]  EXM_Write_Reg = '0;
    logic [31:0] EXM_Result = '0;
    logic        WB_Reg_Write = 1'b0;
    logic [4:0]  WB_Write_Reg = '0;
    logic [31:0] WB_Result = '0;
    logic [31:0] Src1;
    logic [31:0] Src2;
    logic [2:0]  ALU_Control;
    logic        EX_Valid;
    logic        EX_Reg_Write;
    logic [4:0]  EX_Write_Reg;
    logic [31:0] EX_Store_Data;

    id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Stall          (Stall),
        .Flush          (Flush),
        .ID_Valid       (ID_Valid),
        .ID_RD1         (ID_RD1),
        .ID_RD2         (ID_RD2),
        .ID_Imm         (ID_Imm),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_Rd          (ID_Rd),
        .ID_ALU_Src     (ID_ALU_Src),
        .ID_ALU_Control (ID_ALU_Control),
        .ID_Reg_Write   (ID_Reg_Write),
        .ID_Reg_Dst     (ID_Reg_Dst),
        .EXM_Reg_Write  (EXM_Reg_Write),
        .EXM_Write_Reg  (EXM_Write_Reg),
        .EXM_Result     (EXM_Result),
        .WB_Reg_Write   (WB_Reg_Write),
        .WB_Write_Reg   (WB_Write_Reg),
        .WB_Result      (WB_Result),
        .Src1           (Src1),
        .Src2           (Src2),
        .ALU_Control    (ALU_Control),
        .EX_Valid       (EX_Valid),
        .EX_Reg_Write   (EX_Reg_Write),
        .EX_Write_Reg   (EX_Write_Reg),
        .EX_Store_Data  (EX_Store_Data)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store;
        logic [2:0]  alu;
        logic        valid;
        logic        reg_write;
        logic [4:0]  write_reg;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string txn, input string field, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", txn, field, act, req);
        end
    endtask

    task automatic push(input string nm, input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] st,
                        input logic [2:0] alu, input logic v, input logic rw, input logic [4:0] wr);
        exp_t e;
        e.src1 = s1; e.src2 = s2; e.store = st; e.alu = alu;
        e.valid = v; e.reg_write = rw; e.write_reg = wr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_id(input logic v, input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic asrc,
                          input logic [2:0] alu, input logic rw, input logic dst);
        ID_Valid = v; ID_RD1 = rd1; ID_RD2 = rd2; ID_Imm = imm;
        ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_ALU_Src = asrc;
        ID_ALU_Control = alu; ID_Reg_Write = rw; ID_Reg_Dst = dst;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] ewr, input logic [31:0] eres,
                           input logic wrw, input logic [4:0] wwr, input logic [31:0] wres);
        EXM_Reg_Write = erw; EXM_Write_Reg = ewr; EXM_Result = eres;
        WB_Reg_Write = wrw; WB_Write_Reg = wwr; WB_Result = wres;
    endtask

    // Inputs change just after the falling edge, after the monitor has sampled.
    task automatic cycle_start();
        @(negedge CLK);
        #1;
    endtask

    exp_t  mon_e;
    string mon_n;

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            check(mon_n, "Src1", Src1, mon_e.src1);
            check(mon_n, "Src2", Src2, mon_e.src2);
            check(mon_n, "EX_Store_Data", EX_Store_Data, mon_e.store);
            check(mon_n, "ALU_Control", {29'd0, ALU_Control}, {29'd0, mon_e.alu});
            check(mon_n, "EX_Valid", {31'd0, EX_Valid}, {31'd0, mon_e.valid});
            check(mon_n, "EX_Reg_Write", {31'd0, EX_Reg_Write}, {31'd0, mon_e.reg_write});
            check(mon_n, "EX_Write_Reg", {27'd0, EX_Write_Reg}, {27'd0, mon_e.write_reg});
            $display("TXN %-12s Src1=%h Src2=%h Store=%h ALU=%b V=%b RW=%b WR=%0d",
                     mon_n, Src1, Src2, EX_Store_Data, ALU_Control, EX_Valid, EX_Reg_Write, EX_Write_Reg);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge CLK);

        cycle_start();
        push("reset", 32'h0, 32'h0, 32'h0, 3'b011, 1'b0, 1'b0, 5'd0);

        // First capture on the edge after reset release.
        cycle_start();
        RST = 1'b1;
        set_id(1'b1, 32'd5, 32'd7, 32'h10, 5'd1, 5'd2, 5'd3, 1'b0, 3'b010, 1'b1, 1'b1);
        push("capture", 32'd5, 32'd7, 32'd7, 3'b010, 1'b1, 1'b1, 5'd3);

        cycle_start();
        set_id(1'b1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd5, 1'b0, 3'b100, 1'b1, 1'b0);
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        push("fwd_exm", FWD ? 32'hAA : 32'h11, 32'h22, 32'h22, 3'b100, 1'b1, 1'b1, 5'd4);

        cycle_start();
        set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        push("fwd_wb", FWD ? 32'hBB : 32'h11, 32'h22, 32'h22, 3'b100, 1'b1, 1'b1, 5'd4);

        cycle_start();
        set_id(1'b1, 32'h33, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 1'b0, 3'b001, 1'b0, 1'b1);
        set_fwd(1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'h44);
        push("reg0", 32'h33, 32'h0, 32'h0, 3'b001, 1'b1, 1'b0, 5'd7);

        cycle_start();
        set_id(1'b0, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 3'b000, 1'b1, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        push("invalid", 32'h1, 32'h2, 32'h2, 3'b000, 1'b0, 1'b0, 5'd2);

        cycle_start();
        set_id(1'b1, 32'h1, 32'd4, 32'hFFFF_FFFC, 5'd6, 5'd8, 5'd9, 1'b1, 3'b010, 1'b1, 1'b0);
        push("imm", 32'h1, 32'hFFFF_FFFC, 32'd4, 3'b010, 1'b1, 1'b1, 5'd8);

        // Stall holds the stage while ID inputs churn; bypass results still flow.
        cycle_start();
        Stall = 1'b1;
        set_id(1'b1, 32'hDEAD, 32'hBEEF, 32'h1234, 5'd3, 5'd3, 5'd3, 1'b0, 3'b000, 1'b0, 1'b1);
        set_fwd(1'b1, 5'd8, 32'h55, 1'b0, 5'd0, 32'h0);
        push("stall1", 32'h1, 32'hFFFF_FFFC, FWD ? 32'h55 : 32'd4, 3'b010, 1'b1, 1'b1, 5'd8);

        cycle_start();
        set_id(1'b0, 32'hCAFE, 32'hF00D, 32'h5678, 5'd9, 5'd9, 5'd9, 1'b0, 3'b101, 1'b1, 1'b1);
        set_fwd(1'b1, 5'd8, 32'h66, 1'b1, 5'd6, 32'h99);
        push("stall2", FWD ? 32'h99 : 32'h1, 32'hFFFF_FFFC, FWD ? 32'h66 : 32'd4, 3'b010, 1'b1, 1'b1, 5'd8);

        cycle_start();
        Flush = 1'b1;
        push("flush", 32'h0, 32'h0, 32'h0, 3'b011, 1'b0, 1'b0, 5'd0);

        cycle_start();
        Stall = 1'b0;
        Flush = 1'b0;
        set_id(1'b1, 32'h100, 32'h200, 32'h0, 5'd10, 5'd11, 5'd12, 1'b0, 3'b110, 1'b1, 1'b1);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h77);
        push("fwd_rt_wb", 32'h100, FWD ? 32'h77 : 32'h200, FWD ? 32'h77 : 32'h200, 3'b110, 1'b1, 1'b1, 5'd12);

        // Mid-run reset clears the stage immediately and blocks the pending capture.
        cycle_start();
        RST = 1'b0;
        push("reset_mid", 32'h0, 32'h0, 32'h0, 3'b011, 1'b0, 1'b0, 5'd0);

        cycle_start();
        RST = 1'b1;
        set_id(1'b1, 32'h3, 32'h4, 32'h0, 5'd13, 5'd14, 5'd15, 1'b0, 3'b100, 1'b1, 1'b0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        push("recapture", 32'h3, 32'h4, 32'h4, 3'b100, 1'b1, 1'b1, 5'd14);

        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter REG_AW, default 5, register-specifier width.
REQ-003 SHALL have port CLK  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports Stall in 1 (hold stage contents) and Flush in 1 (insert bubble).
REQ-006 SHALL have ports ID_Valid in 1, ID_RD1 and ID_RD2 in DATA_W (register-file reads), and ID_Imm in DATA_W (sign-extended immediate).
REQ-007 SHALL have ports ID_Rs, ID_Rt and ID_Rd in REG_AW (source and destination specifiers).
REQ-008 SHALL have ports ID_ALU_Src in 1 (1=immediate), ID_ALU_Control in 3, ID_Reg_Write in 1 and ID_Reg_Dst in 1 (1=Rd, 0=Rt).
REQ-009 SHALL have forwarding sources EXM_Reg_Write in 1, EXM_Write_Reg in REG_AW and EXM_Result in DATA_W, plus WB_Reg_Write, WB_Write_Reg and WB_Result with the same widths.
REQ-010 SHALL have outputs Src1 and Src2 (DATA_W) and ALU_Control (3), all feeding ALU_32bit directly.
REQ-011 SHALL have outputs EX_Valid (1), EX_Reg_Write (1), EX_Write_Reg (REG_AW) and EX_Store_Data (DATA_W).

Function
REQ-012 SHALL register all ID_* inputs on each rising CLK edge when Flush=0 and Stall=0; latency is 1 cycle.
REQ-013 SHALL load a bubble when Flush=1: Valid=0, Reg_Write=0, ALU_Control=3'b011 (NOP, ALU result 0), other fields 0.
REQ-014 SHALL give Flush priority over Stall when both are 1 in the same cycle.
REQ-015 SHALL hold every stage register unchanged while Stall=1 and Flush=0.
REQ-016 SHALL produce EX_Write_Reg = Reg_Dst_q ? Rd_q : Rt_q combinationally from the registered fields.
REQ-017 SHALL forward the Rs operand combinationally with priority: EXM_Result if EXM_Reg_Write=1, EXM_Write_Reg=Rs_q and Rs_q!=0; otherwise WB_Result if the same conditions hold on WB_*; otherwise RD1_q.
REQ-018 SHALL forward the Rt operand (fwd_rt) by the same rule using Rt_q and RD2_q.
REQ-019 SHALL drive Src1 = fwd_rs, Src2 = ALU_Src_q ? Imm_q : fwd_rt, and EX_Store_Data = fwd_rt.
REQ-020 SHALL never forward for register 0; Src1 and Src2 use the captured RD values when the specifier is 0.
REQ-021 SHALL drive EX_Reg_Write = Reg_Write_q AND Valid_q.
REQ-022 SHALL keep forwarding active during Stall, so held operands track changing EXM/WB results.

Reset
REQ-023 SHALL, on RST low, asynchronously clear all stage registers to 0 except ALU_Control, which resets to 3'b011.
REQ-024 SHALL discard any capture in progress when RST asserts mid-cycle; the first capture occurs on the first rising edge after RST deasserts.

Configuration
REQ-025 SHALL support macro ID_EX_FWD_EN: when defined, forwarding follows REQ-017 to REQ-022.
REQ-026 SHALL, when ID_EX_FWD_EN is undefined, drive fwd_rs=RD1_q and fwd_rt=RD2_q, keep the EXM_*/WB_* ports present but ignored, and leave all other behaviour unchanged.

Structure
REQ-027 SHALL take from shared package mips_pkg: ALU control codes (AND 000, OR 001, ADD 010, NOP 011, SUB 100, MUL 101, SLT 110), DATA_W and REG_AW defaults.
REQ-028 SHALL implement forwarding in sub-module fwd_mux, instantiated twice (rs, rt).

Verification
REQ-029 SHALL verify capture: ID_RD1=5, ID_RD2=7, ALU_Src=0, ALU_Control=010, Rs=1, Rt=2, no forwarding -> next cycle Src1=5, Src2=7, ALU_Control=010.
REQ-030 SHALL verify forwarding priority: Rs_q=3, EXM_Reg_Write=1 with EXM_Write_Reg=3 and EXM_Result=0xAA, WB_Reg_Write=1 with WB_Write_Reg=3 and WB_Result=0xBB -> Src1=0xAA; with EXM_Reg_Write=0 -> Src1=0xBB.
REQ-031 SHALL verify the register-0 rule: Rt_q=0, RD2_q=0, EXM_Write_Reg=0, EXM_Reg_Write=1, EXM_Result=9 -> fwd_rt=0 and EX_Store_Data=0.
REQ-032 SHALL verify Stall/Flush: Stall=1 for 2 cycles while ID inputs change -> outputs hold; Stall=1 with Flush=1 -> EX_Valid=0, EX_Reg_Write=0, ALU_Control=011.
REQ-033 SHALL verify reset: RST low mid-operation -> within the same cycle Src1=0, Src2=0, ALU_Control=011, EX_Valid=0.
REQ-034 SHALL verify immediate select: ALU_Src=1, Imm=0xFFFFFFFC, RD2=4 -> Src2=0xFFFFFFFC and EX_Store_Data=4.
